// File: rtl/axi4l_regfile_slave.sv
// AXI4-Lite responder for a bank of NUM_REGS 32-bit control registers.
// Write address/data are captured independently and committed together; reads return in one cycle.
module axi4l_regfile_slave #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] held_addr;
  logic [DATA_WIDTH-1:0] held_data;
  logic [STRB_W-1:0]     held_strb;
  logic                  commit;
  logic                  aw_in_range;
  logic                  ar_in_range;
  logic [IDX_W-1:0]      aw_idx;
  logic [IDX_W-1:0]      ar_idx;
  logic                  unused_prot;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready never depends on valid, and each ready is held low while its response is pending.
  assign awready = !areset && !aw_held && !bvalid;
  assign wready  = !areset && !w_held && !bvalid;
  assign arready = !areset && !rvalid;

  assign commit      = aw_held && w_held && !bvalid;
  assign aw_in_range = held_addr < ADDR_LIMIT;
  assign aw_idx      = held_addr[IDX_W+1:2];
  assign ar_in_range = araddr < ADDR_LIMIT;
  assign ar_idx      = araddr[IDX_W+1:2];
  assign unused_prot = ^{awprot, arprot};

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      held_addr <= '0;
      held_data <= '0;
      held_strb <= '0;
      bvalid    <= 1'b0;
      bresp     <= RESP_OKAY;
      wr_pulse  <= '0;
    end else begin
      wr_pulse <= '0;
      if (awvalid && awready) begin
        aw_held   <= 1'b1;
        held_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_held    <= 1'b1;
        held_data <= wdata;
        held_strb <= wstrb;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_in_range ? RESP_OKAY : RESP_DECERR;
        if (aw_in_range) begin
          wr_pulse <= NUM_REGS'(1) << aw_idx;
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // Byte-lane merge: lanes with a clear strobe keep their previous contents.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (commit && aw_in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (held_strb[b]) begin
          regs[aw_idx][8*b +: 8] <= held_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= ar_in_range ? regs[ar_idx] : '0;
      rresp  <= ar_in_range ? RESP_OKAY : RESP_DECERR;
    end else if (rvalid && rready) begin
      rvalid <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
    assign reg_out[DATA_WIDTH*g +: DATA_WIDTH] = regs[g];
  end
endmodule
